// File: rtl/regfile_mp_scoreboard_if.sv
// Register file bus: read ports, write/release ports, reservation ports, flush.
// The master side is the core (issue + writeback); the slave side is the register file.
interface regfile_mp_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 4,
  parameter int NWR   = 2,
  parameter int NRES  = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*XLEN-1:0]  wr_data;
  logic [NWR-1:0]       wr_release;
  logic [NRES-1:0]      res_en;
  logic [NRES*AW-1:0]   res_addr;
  logic [NRES-1:0]      res_ok;
  logic                 flush;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_release, res_en, res_addr, flush,
    input  rd_data, rd_busy, res_ok
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_release, res_en, res_addr, flush,
    output rd_data, rd_busy, res_ok
  );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Multi-ported integer register file with optional write-to-read bypass and
// a per-register pending-write counter used by issue to detect RAW hazards.
// x0 is hardwired to zero and never busy. Higher write-port index wins conflicts.
module regfile_mp_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 4,
  parameter int NWR    = 2,
  parameter int NRES   = 2,
  parameter int BYPASS = 1,
  parameter int PCNT_W = 2
) (
  input logic clk,
  input logic reset,
  regfile_mp_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [PCNT_W-1:0] CMAX = {PCNT_W{1'b1}};

  if (NRD < 1 || NWR < 1 || NRES < 1 || PCNT_W < 1 || NREGS < 2 ||
      (NREGS & (NREGS - 1)) != 0) begin : g_bad_params
    $error("regfile_mp_scoreboard: illegal parameter set");
  end

  logic [XLEN-1:0]   r_regs [NREGS];
  logic [PCNT_W-1:0] r_cnt  [NREGS];

  logic [NRD*XLEN-1:0] w_rd_data;
  logic [NRD-1:0]      w_rd_busy;
  logic [PCNT_W-1:0]   w_cnt_nxt [NREGS];
  logic [NRES-1:0]     w_res_ok;

  // Read ports: stored value, overridden by same-cycle writes when bypass is on;
  // ascending scan lets the highest-index matching write win.
  always_comb begin
    logic [AW-1:0] a;
    a         = '0;
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      a = bus.rd_addr[i*AW +: AW];
      if (a != '0) begin
        w_rd_data[i*XLEN +: XLEN] = r_regs[a];
        w_rd_busy[i]              = (r_cnt[a] != '0);
        if (BYPASS != 0) begin
          for (int j = 0; j < NWR; j++) begin
            if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == a)
              w_rd_data[i*XLEN +: XLEN] = bus.wr_data[j*XLEN +: XLEN];
          end
        end
      end
    end
  end

  // Next pending counts: releases first (floored at 0), then reservations in
  // ascending port order against the running total, refused at saturation.
  always_comb begin
    int            rel;
    logic [AW-1:0] a;
    rel      = 0;
    a        = '0;
    w_res_ok = '1;
    for (int r = 0; r < NREGS; r++) begin
      rel = 0;
      for (int j = 0; j < NWR; j++) begin
        if (bus.wr_en[j] && bus.wr_release[j] && bus.wr_addr[j*AW +: AW] != '0 &&
            bus.wr_addr[j*AW +: AW] == AW'(r))
          rel = rel + 1;
      end
      w_cnt_nxt[r] = (rel >= int'(r_cnt[r])) ? '0 : r_cnt[r] - PCNT_W'(rel);
    end
    for (int k = 0; k < NRES; k++) begin
      a = bus.res_addr[k*AW +: AW];
      if (a != '0) begin
        if (w_cnt_nxt[a] == CMAX)
          w_res_ok[k] = 1'b0;
        else if (bus.res_en[k])
          w_cnt_nxt[a] = w_cnt_nxt[a] + 1'b1;
      end
    end
  end

  // Storage: ascending port order so the highest-index write to an address lands last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] != '0)
          r_regs[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
      end
    end
  end

  // Pending counters: flush drops everything, including that cycle's reservations.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) r_cnt[r] <= '0;
    end else if (bus.flush) begin
      for (int r = 0; r < NREGS; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) r_cnt[r] <= w_cnt_nxt[r];
    end
  end

  assign bus.rd_data = w_rd_data;
  assign bus.rd_busy = w_rd_busy;
  assign bus.res_ok  = w_res_ok;
endmodule
